// File: rtl/jpl_foc_pkg.sv
// Shared types and constants for the FOC Park stage.
// Holds the FSM state set, quadrant type and sine ROM generator.
package jpl_foc_pkg;

  localparam int PARK_B  = 12;
  localparam int PARK_C  = 12;
  localparam int PARK_AW = 10;

  function automatic int fs_of(int c);
    return (1 << (c - 1)) - 1;
  endfunction

  function automatic int rnd_of(int c);
    return 1 << (c - 2);
  endfunction

  localparam int COEF_FS = fs_of(PARK_C);
  localparam int RND_K   = rnd_of(PARK_C);

  typedef enum logic [2:0] {
    IDLE, LUT, M0, M1, M2, M3, DONE
  } park_st_e;

  typedef enum logic [1:0] {
    QUAD_0, QUAD_1, QUAD_2, QUAD_3
  } quad_e;

  // sin(i/qn * pi/2) * full-scale, Taylor series in Q30
  function automatic int sin_rom(int i, int qn, int c);
    longint x;
    longint x2;
    longint t;
    longint s;
    x  = (longint'(1686629713) * i) / qn;
    x2 = (x * x) >>> 30;
    t  = x;
    s  = x;
    for (int k = 1; k <= 8; k++) begin
      t = -((t * x2) >>> 30) / ((2 * k) * (2 * k + 1));
      s = s + t;
    end
    return int'((s * fs_of(c) + (longint'(1) <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/jpl_foc_park_if.sv
// Park stage request/result bundle.
// master drives operands and start, slave returns d/q.
interface jpl_foc_park_if
  import jpl_foc_pkg::*;
#(
  parameter int B       = PARK_B,
  parameter int ANGLE_W = PARK_AW
);

  logic                i_start_park;
  logic signed [B-1:0] i_ialpha;
  logic signed [B-1:0] i_ibeta;
  logic [ANGLE_W-1:0]  i_theta;
  logic                o_busy;
  logic                o_park_done;
  logic signed [B-1:0] o_id;
  logic signed [B-1:0] o_iq;
  logic                o_overrun;

  modport master (
    output i_start_park, i_ialpha, i_ibeta, i_theta,
    input  o_busy, o_park_done, o_id, o_iq, o_overrun
  );

  modport slave (
    input  i_start_park, i_ialpha, i_ibeta, i_theta,
    output o_busy, o_park_done, o_id, o_iq, o_overrun
  );

endinterface

// File: rtl/jpl_foc_sincos_lut.sv
// Quarter-wave sine ROM with quadrant folding.
// Registered sin/cos of theta, one cycle latency.
module jpl_foc_sincos_lut
  import jpl_foc_pkg::*;
#(
  parameter int C       = PARK_C,
  parameter int ANGLE_W = PARK_AW
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [ANGLE_W-1:0]  i_theta,
  output logic signed [C-1:0] o_sin,
  output logic signed [C-1:0] o_cos
);

  localparam int QW = ANGLE_W - 2;
  localparam int QN = 1 << QW;

  logic signed [C-1:0] rom [0:QN];
  logic [ANGLE_W-1:0]  th_c;

  for (genvar g = 0; g <= QN; g++) begin : g_rom
    localparam logic signed [C-1:0] V = C'(sin_rom(g, QN, C));
    assign rom[g] = V;
  end

  // cos is sin a quarter turn ahead, wrapping mod full turn
  assign th_c = i_theta + ANGLE_W'(QN);

  function automatic logic signed [C-1:0] fold(
    logic [ANGLE_W-1:0] th
  );
    quad_e         q;
    logic [QW-1:0] ix;
    logic [QW:0]   fx;
    q  = quad_e'(th[ANGLE_W-1 -: 2]);
    ix = th[QW-1:0];
    if (q == QUAD_1 || q == QUAD_3)
      fx = (QW+1)'(QN) - {1'b0, ix};
    else
      fx = {1'b0, ix};
    if (q == QUAD_2 || q == QUAD_3)
      return -rom[fx];
    return rom[fx];
  endfunction

  // register folded sin/cos every cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sin <= '0;
      o_cos <= '0;
    end else begin
      o_sin <= fold(i_theta);
      o_cos <= fold(th_c);
    end
  end

endmodule

// File: rtl/jpl_foc_park.sv
// Park transform (alpha,beta) -> (d,q) on one shared multiplier.
// Define JPL_FOC_PARK_SAT_EN to clamp d/q instead of wrapping.
module jpl_foc_park
  import jpl_foc_pkg::*;
#(
  parameter int B       = PARK_B,
  parameter int C       = PARK_C,
  parameter int ANGLE_W = PARK_AW
) (
  input logic            i_clk,
  input logic            i_rst,
  jpl_foc_park_if.slave  park
);

  localparam int P = B + C;
  localparam int A = B + C + 1;
  localparam int R = A - (C - 1);

  park_st_e st, st_nx;

  logic signed [B-1:0] a_r, b_r;
  logic [ANGLE_W-1:0]  th_r;
  logic signed [C-1:0] sin_v, cos_v;
  logic signed [B-1:0] mx;
  logic signed [C-1:0] my;
  logic signed [P-1:0] prod;
  logic signed [A-1:0] prod_x;
  logic signed [A-1:0] acc_d, acc_q, acc_q_nx;
  logic signed [B-1:0] id_r, iq_r;
  logic                done_r, ovr_r, start_ok;

  jpl_foc_sincos_lut #(
    .C       (C),
    .ANGLE_W (ANGLE_W)
  ) u_lut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_theta (th_r),
    .o_sin   (sin_v),
    .o_cos   (cos_v)
  );

  function automatic logic signed [B-1:0] narrow(
    logic signed [A-1:0] acc
  );
    logic signed [A-1:0] s;
    logic signed [R-1:0] r;
    logic signed [B-1:0] n;
`ifdef JPL_FOC_PARK_SAT_EN
    localparam logic signed [R-1:0] R_MAX = R'((1 << (B-1)) - 1);
    localparam logic signed [R-1:0] R_MIN = R'(-(1 << (B-1)));
`endif
    s = acc + A'(rnd_of(C));
    r = R'(s >>> (C - 1));
    n = B'(r);
`ifdef JPL_FOC_PARK_SAT_EN
    if (r > R_MAX)
      n = B'(R_MAX);
    else if (r < R_MIN)
      n = B'(R_MIN);
`endif
    return n;
  endfunction

  assign start_ok = park.i_start_park && (st == IDLE);

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) st <= IDLE;
    else       st <= st_nx;
  end

  // fixed sequence, leaves IDLE only on start
  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (park.i_start_park) st_nx = LUT;
      LUT:     st_nx = M0;
      M0:      st_nx = M1;
      M1:      st_nx = M2;
      M2:      st_nx = M3;
      M3:      st_nx = DONE;
      DONE:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // operand select for the shared multiplier
  always_comb begin
    mx = a_r;
    my = cos_v;
    unique case (st)
      M1:      begin mx = b_r; my = sin_v; end
      M2:      begin mx = a_r; my = sin_v; end
      M3:      begin mx = b_r; my = cos_v; end
      default: ;
    endcase
  end

  assign prod     = P'(mx) * P'(my);
  assign prod_x   = A'(prod);
  assign acc_q_nx = acc_q + prod_x;

  // operand capture and accumulation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_r   <= '0;
      b_r   <= '0;
      th_r  <= '0;
      acc_d <= '0;
      acc_q <= '0;
    end else begin
      if (start_ok) begin
        a_r  <= park.i_ialpha;
        b_r  <= park.i_ibeta;
        th_r <= park.i_theta;
      end
      unique case (st)
        M0:      acc_d <= prod_x;
        M1:      acc_d <= acc_d + prod_x;
        M2:      acc_q <= -prod_x;
        M3:      acc_q <= acc_q_nx;
        default: ;
      endcase
    end
  end

  // results land on entry to DONE so they coincide with the pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      id_r   <= '0;
      iq_r   <= '0;
      done_r <= 1'b0;
      ovr_r  <= 1'b0;
    end else begin
      done_r <= (st == M3);
      if (st == M3) begin
        id_r <= narrow(acc_d);
        iq_r <= narrow(acc_q_nx);
      end
      if (park.i_start_park && st != IDLE)
        ovr_r <= 1'b1;
    end
  end

  assign park.o_busy      = (st != IDLE);
  assign park.o_park_done = done_r;
  assign park.o_id        = id_r;
  assign park.o_iq        = iq_r;
  assign park.o_overrun   = ovr_r;

endmodule

// File: tb/tb_jpl_foc_park.sv
// Directed bench for jpl_foc_park.
// Hand-computed vectors plus a theta sweep against cos/sin.
module tb_jpl_foc_park;
  import jpl_foc_pkg::*;

  localparam int B  = 12;
  localparam int C  = 12;
  localparam int AW = 10;

  logic i_clk = 1'b0;
  logic i_rst;
  int   n_run  = 0;
  int   n_fail = 0;

  jpl_foc_park_if #(.B(B), .ANGLE_W(AW)) pif ();

  jpl_foc_park #(
    .B       (B),
    .C       (C),
    .ANGLE_W (AW)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .park  (pif)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got,
                     input int want, input int tol = 0);
    int d;
    n_run++;
    d = got - want;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, input int th);
    pif.i_ialpha = B'(a);
    pif.i_ibeta  = B'(b);
    pif.i_theta  = AW'(th);
  endtask

  task automatic run_park(input int a, input int b, input int th,
                          output int id, output int iq,
                          output int lat);
    drive(a, b, th);
    pif.i_start_park = 1'b1;
    step();
    pif.i_start_park = 1'b0;
    drive(int'($urandom), int'($urandom), int'($urandom));
    lat = 0;
    id  = 0;
    iq  = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge i_clk);
      if (pif.o_park_done) begin
        lat = k;
        id  = pif.o_id;
        iq  = pif.o_iq;
      end
      step();
    end
  endtask

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  initial begin
    int  id, iq, lat, nd, dc;
    real sc, ang;

    pif.i_start_park = 1'b0;
    drive(0, 0, 0);
    i_rst = 1'b1;
    repeat (3) step();
    @(negedge i_clk);
    chk("rst_busy", pif.o_busy, 0);
    chk("rst_done", pif.o_park_done, 0);
    chk("rst_id", pif.o_id, 0);
    chk("rst_iq", pif.o_iq, 0);
    chk("rst_ovr", pif.o_overrun, 0);
    step();
    i_rst = 1'b0;
    step();

    drive(1000, -500, 0);
    pif.i_start_park = 1'b1;
    @(negedge i_clk);
    chk("c0_busy", pif.o_busy, 0);
    step();
    pif.i_start_park = 1'b0;
    drive(77, 33, 300);
    for (int c = 1; c <= 7; c++) begin
      @(negedge i_clk);
      chk($sformatf("busy_c%0d", c), pif.o_busy, int'(c <= 6));
      chk($sformatf("done_c%0d", c), pif.o_park_done, int'(c == 6));
      if (c == 6) begin
        chk("t0_id", pif.o_id, 1000);
        chk("t0_iq", pif.o_iq, -500);
      end
      step();
    end

    run_park(1000, -500, 256, id, iq, lat);
    chk("t90_lat", lat, 6);
    chk("t90_id", id, -500);
    chk("t90_iq", iq, -1000);

    run_park(1000, -500, 512, id, iq, lat);
    chk("t180_lat", lat, 6);
    chk("t180_id", id, -1000);
    chk("t180_iq", iq, 500);

    run_park(1000, -500, 768, id, iq, lat);
    chk("t270_lat", lat, 6);
    chk("t270_id", id, 500);
    chk("t270_iq", iq, 1000);

    run_park(2047, 2047, 128, id, iq, lat);
    chk("t45_lat", lat, 6);
`ifdef JPL_FOC_PARK_SAT_EN
    chk("t45_id", id, 2047);
`else
    chk("t45_id", id, -1203);
`endif
    chk("t45_iq", iq, 0);
    chk("ovr_pre", pif.o_overrun, 0);

    drive(1000, -500, 0);
    pif.i_start_park = 1'b1;
    step();
    pif.i_start_park = 1'b0;
    step();
    step();
    drive(300, 700, 256);
    pif.i_start_park = 1'b1;
    step();
    pif.i_start_park = 1'b0;
    nd = 0;
    dc = 0;
    for (int c = 4; c <= 14; c++) begin
      @(negedge i_clk);
      if (pif.o_park_done) begin
        nd++;
        if (dc == 0) begin
          dc = c;
          id = pif.o_id;
          iq = pif.o_iq;
        end
      end
      step();
    end
    chk("ovr_ndone", nd, 1);
    chk("ovr_cyc", dc, 6);
    chk("ovr_id", id, 1000);
    chk("ovr_iq", iq, -500);
    chk("ovr_flag", pif.o_overrun, 1);

    run_park(1000, -500, 512, id, iq, lat);
    chk("ovr2_lat", lat, 6);
    chk("ovr2_id", id, -1000);
    chk("ovr2_flag", pif.o_overrun, 1);

    drive(1000, -500, 256);
    pif.i_start_park = 1'b1;
    step();
    pif.i_start_park = 1'b0;
    step();
    step();
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("mrst_busy", pif.o_busy, 0);
    chk("mrst_id", pif.o_id, 0);
    chk("mrst_iq", pif.o_iq, 0);
    chk("mrst_ovr", pif.o_overrun, 0);
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      if (pif.o_park_done) nd++;
      step();
      @(negedge i_clk);
    end
    step();
    chk("mrst_ndone", nd, 0);

    run_park(1000, -500, 256, id, iq, lat);
    chk("post_lat", lat, 6);
    chk("post_id", id, -500);
    chk("post_iq", iq, -1000);

    drive(1000, -500, 0);
    pif.i_start_park = 1'b1;
    step();
    pif.i_start_park = 1'b0;
    repeat (5) step();
    pif.i_start_park = 1'b1;
    @(negedge i_clk);
    chk("dn_done", pif.o_park_done, 1);
    step();
    pif.i_start_park = 1'b0;
    @(negedge i_clk);
    chk("dn_ovr", pif.o_overrun, 1);
    chk("dn_busy", pif.o_busy, 0);
    step();

    sc = real'(COEF_FS) / (2.0 * real'(RND_K));
    for (int t = 0; t < 1024; t++) begin
      run_park(1000, 0, t, id, iq, lat);
      ang = 6.283185307179586 * real'(t) / 1024.0;
      chk($sformatf("sw_lat_%0d", t), lat, 6);
      chk($sformatf("sw_id_%0d", t), id,
          rnd(1000.0 * $cos(ang) * sc), 1);
      chk($sformatf("sw_iq_%0d", t), iq,
          rnd(-1000.0 * $sin(ang) * sc), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
